// File: rtl/boolexp_lut_eval.sv
// Programmable N-input Boolean function held as a 2^N-entry truth table, with
// registered single-vector evaluation and an autonomous truth-table sweep.
module boolexp_lut_eval #(
  parameter int               N        = 4,
  parameter logic [(2**N)-1:0] RESET_TT = 16'h0703
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        x,
  input  logic                in_valid,
  output logic                y,
  output logic                y_valid,
  input  logic                cfg_we,
  input  logic [N-1:0]        cfg_addr,
  input  logic                cfg_data,
  input  logic                tt_load,
  input  logic [(2**N)-1:0]   tt_in,
  input  logic                start,
  output logic                busy,
  output logic                sw_valid,
  output logic [N-1:0]        sw_idx,
  output logic                sw_y,
  output logic                done,
  output logic [N:0]          ones_count
);

  localparam int         DEPTH = 2**N;
  localparam logic [N:0] LAST  = (N+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state_q;
  logic [DEPTH-1:0] tt_q, tt_d;
  logic [N:0]       cnt_q;
  logic [N:0]       acc_q;
  logic             y_q, y_valid_q;
  logic             sw_valid_q, sw_y_q, done_q;
  logic [N-1:0]     sw_idx_q;
  logic [N:0]       ones_q;

  assign busy = (state_q != IDLE);

  // The table is frozen while busy; a full load takes priority over an entry write.
  always_comb begin
    tt_d = tt_q;
    if (!busy) begin
      if (tt_load)     tt_d = tt_in;
      else if (cfg_we) tt_d[cfg_addr] = cfg_data;
    end
  end

  // Evaluation reads the pre-write table, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q      <= RESET_TT;
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      tt_q      <= tt_d;
      y_valid_q <= in_valid;
      if (in_valid) y_q <= tt_q[x];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      sw_valid_q <= 1'b0;
      sw_idx_q   <= '0;
      sw_y_q     <= 1'b0;
      done_q     <= 1'b0;
      ones_q     <= '0;
    end else begin
      sw_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        SWEEP: begin
          sw_valid_q <= 1'b1;
          sw_idx_q   <= cnt_q[N-1:0];
          sw_y_q     <= tt_q[cnt_q[N-1:0]];
          acc_q      <= acc_q + (N+1)'(tt_q[cnt_q[N-1:0]]);
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          ones_q  <= acc_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y          = y_q;
  assign y_valid    = y_valid_q;
  assign sw_valid   = sw_valid_q;
  assign sw_idx     = sw_idx_q;
  assign sw_y       = sw_y_q;
  assign done       = done_q;
  assign ones_count = ones_q;

endmodule
